// File: rtl/fabscalar_pkg.sv
// rtl/fabscalar_pkg.sv - shared machine parameters for the instruction buffer / rename boundary
package fabscalar_pkg;

  localparam int DISPATCH_WIDTH  = 4;
  localparam int DECODED_PKT_W   = 32;
  localparam int BRANCH_FLAG_BIT = 31;
  localparam int NUM_CHECKPOINTS = 4;
  localparam int CKPT_W          = $clog2(NUM_CHECKPOINTS + 1);
  localparam int BRANCH_COUNT    = $clog2(DISPATCH_WIDTH + 1);
  localparam int BRANCH_COUNT_W  = BRANCH_COUNT;

  function automatic logic is_branch(input logic [DECODED_PKT_W-1:0] pkt);
    return pkt[BRANCH_FLAG_BIT];
  endfunction

endpackage

// File: rtl/ibuf_rename_drain_if.sv
// rtl/ibuf_rename_drain_if.sv - buffer-head, rename and checkpoint signals of the drain stage
interface ibuf_rename_drain_if
  import fabscalar_pkg::*;
#(
  parameter int PKT_W          = DECODED_PKT_W,
  parameter int CKPT_W_P       = CKPT_W,
  parameter int BRANCH_COUNT_P = BRANCH_COUNT_W
);
  logic                      flush_i;
  logic                      instBufferReady_i;
  logic [PKT_W-1:0]          decodedPacket0_i;
  logic [PKT_W-1:0]          decodedPacket1_i;
  logic [PKT_W-1:0]          decodedPacket2_i;
  logic [PKT_W-1:0]          decodedPacket3_i;
  logic [BRANCH_COUNT_P-1:0] branchCount_i;
  logic                      stall_o;
  logic                      renameStall_i;
  logic [CKPT_W_P-1:0]       ckptRelease_i;
  logic                      renameReady_o;
  logic [PKT_W-1:0]          renamePacket0_o;
  logic [PKT_W-1:0]          renamePacket1_o;
  logic [PKT_W-1:0]          renamePacket2_o;
  logic [PKT_W-1:0]          renamePacket3_o;
  logic [CKPT_W_P-1:0]       freeCkpt_o;

  modport master (
    output flush_i, instBufferReady_i, decodedPacket0_i, decodedPacket1_i,
           decodedPacket2_i, decodedPacket3_i, branchCount_i, renameStall_i, ckptRelease_i,
    input  stall_o, renameReady_o, renamePacket0_o, renamePacket1_o,
           renamePacket2_o, renamePacket3_o, freeCkpt_o
  );

  modport slave (
    input  flush_i, instBufferReady_i, decodedPacket0_i, decodedPacket1_i,
           decodedPacket2_i, decodedPacket3_i, branchCount_i, renameStall_i, ckptRelease_i,
    output stall_o, renameReady_o, renamePacket0_o, renamePacket1_o,
           renamePacket2_o, renamePacket3_o, freeCkpt_o
  );
endinterface

// File: rtl/ibuf_rename_drain_ckpt.sv
// rtl/ibuf_rename_drain_ckpt.sv - free branch checkpoint counter with flush reload and saturation
module ckpt_free_counter
  import fabscalar_pkg::*;
#(
  parameter int NUM_CKPT = NUM_CHECKPOINTS,
  parameter int CW       = CKPT_W,
  parameter int BW       = BRANCH_COUNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic [CW-1:0] release_i,
  input  logic [BW-1:0] consume_i,
  output logic [CW-1:0] free_o
);
  localparam logic [CW:0] MAX_SUM = (CW+1)'(NUM_CKPT);

  logic [CW-1:0] r_free;
  logic [CW:0]   w_sum;
  logic [CW-1:0] w_next;

  // One extra bit so an over-release is visible before clamping
  always_comb begin
    w_sum  = (CW+1)'(r_free) + (CW+1)'(release_i) - (CW+1)'(consume_i);
    w_next = (w_sum > MAX_SUM) ? CW'(NUM_CKPT) : w_sum[CW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_free <= CW'(NUM_CKPT);
    end else if (flush_i) begin
      r_free <= CW'(NUM_CKPT);
    end else begin
      r_free <= w_next;
    end
  end

  always @(posedge clk) begin
    if (!rst && !flush_i) begin
      assert (w_sum <= MAX_SUM);
    end
  end

  assign free_o = r_free;
endmodule

// File: rtl/ibuf_rename_drain.sv
// rtl/ibuf_rename_drain.sv - takes dispatch groups off the instruction buffer head and registers them for rename
module ibuf_rename_drain
  import fabscalar_pkg::*;
#(
  parameter int PKT_W           = DECODED_PKT_W,
  parameter int NUM_CKPT        = NUM_CHECKPOINTS,
  parameter int CKPT_W_P        = CKPT_W,
  parameter int BRANCH_COUNT_P  = BRANCH_COUNT_W
) (
  input  logic                clk,
  input  logic                reset,
  ibuf_rename_drain_if.slave  bus
);
  logic                      r_ready;
  logic [PKT_W-1:0]          r_pkt0;
  logic [PKT_W-1:0]          r_pkt1;
  logic [PKT_W-1:0]          r_pkt2;
  logic [PKT_W-1:0]          r_pkt3;
  logic [CKPT_W_P-1:0]       w_free;
  logic                      w_hold;
  logic                      w_ckpt_short;
  logic                      w_stall;
  logic                      w_accept;
  logic [BRANCH_COUNT_P-1:0] w_consume;

  // Shortage check uses the registered count so stall has no path from release
  always_comb begin
    w_hold       = r_ready & bus.renameStall_i;
    w_ckpt_short = bus.instBufferReady_i & (CKPT_W_P'(bus.branchCount_i) > w_free);
    w_stall      = reset | bus.flush_i | w_hold | w_ckpt_short;
    w_accept     = bus.instBufferReady_i & ~w_stall;
    w_consume    = w_accept ? bus.branchCount_i : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_pkt0  <= '0;
      r_pkt1  <= '0;
      r_pkt2  <= '0;
      r_pkt3  <= '0;
    end else if (bus.flush_i) begin
      r_ready <= 1'b0;
      r_pkt0  <= '0;
      r_pkt1  <= '0;
      r_pkt2  <= '0;
      r_pkt3  <= '0;
    end else if (w_accept) begin
      r_ready <= 1'b1;
      r_pkt0  <= bus.decodedPacket0_i;
      r_pkt1  <= bus.decodedPacket1_i;
      r_pkt2  <= bus.decodedPacket2_i;
      r_pkt3  <= bus.decodedPacket3_i;
    end else if (!w_hold) begin
      r_ready <= 1'b0;
    end
  end

  ckpt_free_counter #(
    .NUM_CKPT (NUM_CKPT),
    .CW       (CKPT_W_P),
    .BW       (BRANCH_COUNT_P)
  ) u_ckpt (
    .clk       (clk),
    .rst       (reset),
    .flush_i   (bus.flush_i),
    .release_i (bus.ckptRelease_i),
    .consume_i (w_consume),
    .free_o    (w_free)
  );

  assign bus.stall_o         = w_stall;
  assign bus.renameReady_o   = r_ready;
  assign bus.renamePacket0_o = r_pkt0;
  assign bus.renamePacket1_o = r_pkt1;
  assign bus.renamePacket2_o = r_pkt2;
  assign bus.renamePacket3_o = r_pkt3;
  assign bus.freeCkpt_o      = w_free;
endmodule

// File: tb/tb_ibuf_rename_drain.sv
// tb/tb_ibuf_rename_drain.sv - directed bench for ibuf_rename_drain
module tb_ibuf_rename_drain;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ibuf_rename_drain_if bus ();

  ibuf_rename_drain dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [31:0] pkt(input int g, input int lane);
    return 32'hA000_0000 | 32'(g << 8) | 32'(lane);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rdy, input int g, input int bc);
    bus.instBufferReady_i = rdy;
    bus.decodedPacket0_i  = pkt(g, 0);
    bus.decodedPacket1_i  = pkt(g, 1);
    bus.decodedPacket2_i  = pkt(g, 2);
    bus.decodedPacket3_i  = pkt(g, 3);
    bus.branchCount_i     = 3'(bc);
  endtask

  task automatic check_group(input string tag, input int g);
    check({tag, "_rdy"}, 32'(bus.renameReady_o), 32'd1);
    check({tag, "_p0"}, bus.renamePacket0_o, pkt(g, 0));
    check({tag, "_p1"}, bus.renamePacket1_o, pkt(g, 1));
    check({tag, "_p2"}, bus.renamePacket2_o, pkt(g, 2));
    check({tag, "_p3"}, bus.renamePacket3_o, pkt(g, 3));
  endtask

  // Advance one clock; drive after negedge, sample registered outputs at next negedge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.flush_i       = 1'b0;
    bus.renameStall_i = 1'b0;
    bus.ckptRelease_i = '0;
    drive(1'b0, 0, 0);
    @(negedge clk);
    check("rst_stall", 32'(bus.stall_o), 32'd1);
    check("rst_ready", 32'(bus.renameReady_o), 32'd0);
    check("rst_free", 32'(bus.freeCkpt_o), 32'd4);
    check("rst_pkt0", bus.renamePacket0_o, 32'd0);

    reset = 1'b0;
    #1 check("empty_stall", 32'(bus.stall_o), 32'd0);
    tick();
    check("empty_ready", 32'(bus.renameReady_o), 32'd0);
    check("empty_free", 32'(bus.freeCkpt_o), 32'd4);

    drive(1'b1, 1, 1);
    #1 check("s1_stall", 32'(bus.stall_o), 32'd0);
    tick();
    check_group("s1", 1);
    check("s1_free", 32'(bus.freeCkpt_o), 32'd3);
    drive(1'b1, 2, 1);
    #1 check("s2_stall", 32'(bus.stall_o), 32'd0);
    tick();
    check_group("s2", 2);
    check("s2_free", 32'(bus.freeCkpt_o), 32'd2);
    drive(1'b1, 3, 1);
    #1 check("s3_stall", 32'(bus.stall_o), 32'd0);
    tick();
    check_group("s3", 3);
    check("s3_free", 32'(bus.freeCkpt_o), 32'd1);

    drive(1'b1, 4, 2);
    #1 check("short_stall", 32'(bus.stall_o), 32'd1);
    tick();
    check("short_drain", 32'(bus.renameReady_o), 32'd0);
    check("short_keep_p0", bus.renamePacket0_o, pkt(3, 0));
    check("short_free", 32'(bus.freeCkpt_o), 32'd1);
    bus.ckptRelease_i = 3'd1;
    #1 check("rel_stall", 32'(bus.stall_o), 32'd1);
    tick();
    check("rel_free", 32'(bus.freeCkpt_o), 32'd2);
    check("rel_ready", 32'(bus.renameReady_o), 32'd0);
    bus.ckptRelease_i = 3'd0;
    #1 check("short_go_stall", 32'(bus.stall_o), 32'd0);
    tick();
    check_group("short_go", 4);
    check("short_go_free", 32'(bus.freeCkpt_o), 32'd0);

    bus.renameStall_i = 1'b1;
    drive(1'b1, 5, 0);
    #1 check("bp_stall", 32'(bus.stall_o), 32'd1);
    tick();
    check_group("bp_hold1", 4);
    check("bp_stall2", 32'(bus.stall_o), 32'd1);
    tick();
    check_group("bp_hold2", 4);
    bus.renameStall_i = 1'b0;
    #1 check("bp_rel_stall", 32'(bus.stall_o), 32'd0);
    tick();
    check_group("bp_next", 5);
    check("bp_free", 32'(bus.freeCkpt_o), 32'd0);

    bus.renameStall_i = 1'b1;
    bus.ckptRelease_i = 3'd1;
    drive(1'b0, 6, 0);
    tick();
    check("fl_pre_free", 32'(bus.freeCkpt_o), 32'd1);
    check_group("fl_pre_hold", 5);
    bus.flush_i = 1'b1;
    drive(1'b1, 6, 0);
    #1 check("fl_stall", 32'(bus.stall_o), 32'd1);
    tick();
    check("fl_ready", 32'(bus.renameReady_o), 32'd0);
    check("fl_p0", bus.renamePacket0_o, 32'd0);
    check("fl_p3", bus.renamePacket3_o, 32'd0);
    check("fl_free", 32'(bus.freeCkpt_o), 32'd4);

    bus.flush_i       = 1'b0;
    bus.renameStall_i = 1'b0;
    bus.ckptRelease_i = 3'd0;
    drive(1'b1, 7, 1);
    tick();
    check_group("ar_pre", 7);
    check("ar_pre_free", 32'(bus.freeCkpt_o), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("ar_ready", 32'(bus.renameReady_o), 32'd0);
    check("ar_p0", bus.renamePacket0_o, 32'd0);
    check("ar_free", 32'(bus.freeCkpt_o), 32'd4);
    check("ar_stall", 32'(bus.stall_o), 32'd1);
    tick();
    reset = 1'b0;
    drive(1'b0, 0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
